// File: rtl/debug_step_ctrl_pkg.sv
// Shared types and constants for the debug stepping/trace controller.
// Build option: DEBUG_BRANCH_FOLLOW_EN (uses branchOffset for B/BL targets).
package debug_step_ctrl_pkg;

   typedef enum logic [2:0] {
      CLS_OTHER = 3'd0,
      CLS_MOV   = 3'd1,
      CLS_STR   = 3'd2,
      CLS_LDR   = 3'd3,
      CLS_ADD   = 3'd4,
      CLS_SUB   = 3'd5,
      CLS_AND   = 3'd6,
      CLS_BR    = 3'd7
   } iclass_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN_N    = 2'd1,
      ST_RUN_BP   = 2'd2,
      ST_RUN_FREE = 2'd3
   } state_e;

   localparam logic [1:0] MODE_STEP     = 2'd0;
   localparam logic [1:0] MODE_RUN_N    = 2'd1;
   localparam logic [1:0] MODE_RUN_BP   = 2'd2;
   localparam logic [1:0] MODE_RUN_FREE = 2'd3;

   // Matched against instr[31:20]; '?' bits are don't-care under casez.
   localparam logic [11:0] OP_MOV = 12'hE3A;
   localparam logic [11:0] OP_STR = 12'hE58;
   localparam logic [11:0] OP_LDR = 12'hE59;
   localparam logic [11:0] OP_ADD = 12'hE08;
   localparam logic [11:0] OP_SUB = 12'hE04;
   localparam logic [11:0] OP_AND = 12'hE00;
   localparam logic [11:0] OP_BR  = 12'b1110_101?_????;

   function automatic logic signed [31:0] branchOffset(input logic [31:0] instr);
      return $signed({{6{instr[23]}}, instr[23:0], 2'b00});
   endfunction

endpackage

// File: rtl/debug_step_ctrl_if.sv
// Control/status bundle between the switch/debouncer side and the step controller.
interface debug_step_ctrl_if
   import debug_step_ctrl_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16,
   parameter int DEPTH = 8
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              step_pulse;
   logic              run_pulse;
   logic [1:0]        mode;
   logic [CNT_W-1:0]  run_count;
   logic [PC_W-1:0]   bp_addr;
   logic              bp_en;
   logic [31:0]       instr;
   logic [PC_W-1:0]   pc;
   logic              adv;
   logic              busy;
   logic              bp_hit;
   iclass_e           instr_class;
   logic [CNT_W-1:0]  step_count;
   logic [AW-1:0]     trace_idx;
   logic [PC_W-1:0]   trace_pc;
   logic              trace_valid;

   modport master (
      output step_pulse, run_pulse, mode, run_count, bp_addr, bp_en, instr, trace_idx,
      input  pc, adv, busy, bp_hit, instr_class, step_count, trace_pc, trace_valid
   );

   modport slave (
      input  step_pulse, run_pulse, mode, run_count, bp_addr, bp_en, instr, trace_idx,
      output pc, adv, busy, bp_hit, instr_class, step_count, trace_pc, trace_valid
   );

endinterface

// File: rtl/debug_step_ctrl_classifier.sv
// Combinational instruction classifier; also reused by the HEX4/HEX5 mnemonic driver.
module debug_step_ctrl_classifier
   import debug_step_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output iclass_e     iclass_o
);

   logic unusedLowBits;
   assign unusedLowBits = ^instr_i[19:0];

   // First match in package order wins.
   always_comb begin
      iclass_o = CLS_OTHER;
      casez (instr_i[31:20])
         OP_MOV:  iclass_o = CLS_MOV;
         OP_STR:  iclass_o = CLS_STR;
         OP_LDR:  iclass_o = CLS_LDR;
         OP_ADD:  iclass_o = CLS_ADD;
         OP_SUB:  iclass_o = CLS_SUB;
         OP_AND:  iclass_o = CLS_AND;
         OP_BR:   iclass_o = CLS_BR;
         default: iclass_o = CLS_OTHER;
      endcase
   end

endmodule

// File: rtl/debug_step_ctrl.sv
// Fetch-PC sequencer with step/run-N/run-to-breakpoint/free-run modes and PC history.
// Build option: DEBUG_BRANCH_FOLLOW_EN makes advances on B/BL follow the branch target.
module debug_step_ctrl
   import debug_step_ctrl_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int CNT_W    = 16,
   parameter int RATE_DIV = 25_000_000,
   parameter int DEPTH    = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   debug_step_ctrl_if.slave  dbg
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [RW-1:0] RATE_LAST = RW'(RATE_DIV - 1);
   localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);

   state_e            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;
   logic              adv_q;
   logic              bp_hit_q;
   logic [CNT_W-1:0]  step_count_q;
   logic [CNT_W-1:0]  remain_q;
   logic [RW-1:0]     rate_q;
   logic [AW-1:0]     wptr_q;
   logic [AW:0]       fill_q;
   logic [PC_W-1:0]   tbuf_q [DEPTH];

   iclass_e           iclass;
   logic              running;
   logic              tick;
   logic              abort;
   logic              bpStop;
   logic              advance;
   logic [AW-1:0]     rdIdx;

   debug_step_ctrl_classifier u_classifier (
      .instr_i  (dbg.instr),
      .iclass_o (iclass)
   );

   always_comb begin
      pc_d = pc_q + PC_W'(4);
`ifdef DEBUG_BRANCH_FOLLOW_EN
      if (iclass == CLS_BR) begin
         pc_d = pc_q + PC_W'(8) + PC_W'(branchOffset(dbg.instr));
      end
`endif
   end

   assign running = (state_q != ST_IDLE);
   assign tick    = (rate_q == RATE_LAST);
   assign abort   = running && (dbg.step_pulse || dbg.run_pulse);
   assign bpStop  = dbg.bp_en && (((pc_d ^ dbg.bp_addr) & ~PC_W'(3)) == '0);
   assign advance = running ? (tick && !abort) : dbg.step_pulse;

   // Abort in a run state takes priority over a tick landing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         adv_q        <= 1'b0;
         bp_hit_q     <= 1'b0;
         step_count_q <= '0;
         remain_q     <= '0;
         rate_q       <= '0;
         wptr_q       <= '0;
         fill_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbuf_q[i] <= '0;
         end
      end else begin
         adv_q <= advance;
         if (advance) begin
            pc_q           <= pc_d;
            tbuf_q[wptr_q] <= pc_q;
            wptr_q         <= wptr_q + AW'(1);
            step_count_q   <= step_count_q + CNT_W'(1);
            if (fill_q != FILL_MAX) begin
               fill_q <= fill_q + (AW+1)'(1);
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (dbg.step_pulse) begin
                  bp_hit_q <= 1'b0;
               end else if (dbg.run_pulse && (dbg.mode != MODE_STEP)) begin
                  bp_hit_q <= 1'b0;
                  rate_q   <= '0;
                  case (dbg.mode)
                     MODE_RUN_N: begin
                        if (dbg.run_count != '0) begin
                           remain_q <= dbg.run_count;
                           state_q  <= ST_RUN_N;
                        end
                     end
                     MODE_RUN_BP: state_q <= ST_RUN_BP;
                     default:     state_q <= ST_RUN_FREE;
                  endcase
               end
            end
            default: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (tick) begin
                  rate_q <= '0;
                  if (bpStop) begin
                     bp_hit_q <= 1'b1;
                     state_q  <= ST_IDLE;
                  end else if ((state_q == ST_RUN_N) && (remain_q == CNT_W'(1))) begin
                     state_q <= ST_IDLE;
                  end
                  if (state_q == ST_RUN_N) begin
                     remain_q <= remain_q - CNT_W'(1);
                  end
               end else begin
                  rate_q <= rate_q + RW'(1);
               end
            end
         endcase
      end
   end

   // Index 0 is the most recently pushed PC; power-of-two depth makes the wrap free.
   assign rdIdx = wptr_q - AW'(1) - dbg.trace_idx;

   assign dbg.pc          = pc_q;
   assign dbg.adv         = adv_q;
   assign dbg.busy        = running;
   assign dbg.bp_hit      = bp_hit_q;
   assign dbg.instr_class = iclass;
   assign dbg.step_count  = step_count_q;
   assign dbg.trace_pc    = tbuf_q[rdIdx];
   assign dbg.trace_valid = ({1'b0, dbg.trace_idx} < fill_q);

endmodule
